// File: rtl/gpio_arbiter.sv
// gpio_arbiter: two-requester round-robin front end for the single-register
// GPIO peripheral. It accepts one request at a time, drives the GPIO strobes
// from registered state and returns a one-cycle response pulse per requester.
// The optional masked-write mode is enabled by defining GPIO_ARB_WMASK_EN.
// In that mode every write becomes a read-modify-write and its response
// carries the value the register held before the write.
//
// state | meaning
// IDLE  | waiting for a request; req_ready is decoded combinationally here
// RD    | gpio_rd_en high (reads, and the read half of a masked write)
// WAITR | GPIO read data arrives and is captured at the end of this cycle
// WR    | gpio_wr_en high with gpio_wdata already registered
// RESP  | rsp_valid[owner] high for one cycle

module gpio_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic [DATA_W-1:0] req_wmask0,
  input  logic [DATA_W-1:0] req_wmask1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              gpio_wr_en,
  output logic              gpio_rd_en,
  output logic [DATA_W-1:0] gpio_wdata,
  input  logic [DATA_W-1:0] gpio_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] WAITR = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              owner;
  logic              we_q;
  logic              last_grant;
  logic              win;
  logic              accept;
  logic [DATA_W-1:0] sel_wdata;

`ifdef GPIO_ARB_WMASK_EN
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wmask_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] sel_wmask;
`else
  logic              unused_wmask;
  assign unused_wmask = ^{req_wmask0, req_wmask1};
`endif

  // Winner selection: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    if (req_valid == 2'b11) begin
      win = ~last_grant;
    end else begin
      win = req_valid[1];
    end
    sel_wdata = win ? req_wdata1 : req_wdata0;
`ifdef GPIO_ARB_WMASK_EN
    sel_wmask = win ? req_wmask1 : req_wmask0;
`endif
  end

  assign accept = (state == IDLE) && (req_valid != 2'b00);

  // Accept strobe; also forced low while reset is held so every output reads zero.
  always_comb begin
    req_ready = 2'b00;
    if (accept && resetn) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
  end

  // Next-state decode; writes take the RD/WAITR detour only in masked mode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef GPIO_ARB_WMASK_EN
          state_nxt = RD;
`else
          state_nxt = req_we[win] ? WR : RD;
`endif
        end
      end
      RD:      state_nxt = WAITR;
      WAITR:   state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch owner and direction at accept; last_grant remembers the winner for fairness.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner      <= 1'b0;
      we_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      owner      <= win;
      we_q       <= req_we[win];
      last_grant <= win;
    end
  end

`ifdef GPIO_ARB_WMASK_EN
  // Masked mode: hold write data/mask until the merge, and keep the pre-write value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdata_q <= '0;
      wmask_q <= '0;
      old_q   <= '0;
    end else begin
      if (accept) begin
        wdata_q <= sel_wdata;
        wmask_q <= sel_wmask;
      end
      if (state == WAITR) begin
        old_q <= gpio_rdata;
      end
    end
  end
`endif

  // GPIO write data is registered so it is stable for the whole WR cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio_wdata <= '0;
    end else begin
`ifdef GPIO_ARB_WMASK_EN
      if ((state == WAITR) && we_q) begin
        gpio_wdata <= (gpio_rdata & ~wmask_q) | (wdata_q & wmask_q);
      end
`else
      if (accept && req_we[win]) begin
        gpio_wdata <= sel_wdata;
      end
`endif
    end
  end

  // Response data is loaded on the transition into RESP and then held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_rdata <= '0;
    end else if ((state == WAITR) && !we_q) begin
      rsp_rdata <= gpio_rdata;
    end else if (state == WR) begin
`ifdef GPIO_ARB_WMASK_EN
      rsp_rdata <= old_q;
`else
      rsp_rdata <= '0;
`endif
    end
  end

  // Moore decodes of the registered state.
  always_comb begin
    gpio_rd_en = (state == RD);
    gpio_wr_en = (state == WR);
    rsp_valid  = 2'b00;
    if (state == RESP) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
    end
  end

endmodule
